// File: rtl/i2s_frame_scheduler.sv
// rtl/i2s_frame_scheduler.sv - frame-rate sample scheduler between FM demodulator and I2S transmitter
module i2s_frame_scheduler #(
    parameter int IN_WIDTH     = 10,
    parameter int VOLUME_WIDTH = 4,
    parameter int FRAME_CLK    = 1536,
    parameter int FIFO_AW      = 3,
    parameter int START_LEVEL  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [IN_WIDTH-1:0]     s_left,
    input  logic [IN_WIDTH-1:0]     s_right,
    input  logic                    s_valid,
    input  logic [VOLUME_WIDTH-1:0] volume_req,
    input  logic                    mute,
    output logic [IN_WIDTH-1:0]     out_left,
    output logic [IN_WIDTH-1:0]     out_right,
    output logic [VOLUME_WIDTH-1:0] out_volume,
    output logic                    out_valid,
    output logic                    running,
    output logic [FIFO_AW:0]        fifo_level,
    output logic                    underrun,
    output logic                    overrun
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(FRAME_CLK);
    localparam int LW    = FIFO_AW + 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t                  state_q;
    logic [CW-1:0]           frame_cnt_q;
    logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q, level_d;
    logic [IN_WIDTH-1:0]     mem_left_q  [DEPTH];
    logic [IN_WIDTH-1:0]     mem_right_q [DEPTH];
    logic [IN_WIDTH-1:0]     out_left_q, out_right_q;
    logic [VOLUME_WIDTH-1:0] out_volume_q, vol_target;
    logic                    out_valid_q, running_q, underrun_q, overrun_q;
    logic                    tick, fifo_empty, fifo_full, start_ok;
    logic                    pop, push, mute_zero;

    assign tick       = (frame_cnt_q == CW'(FRAME_CLK - 1));
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    assign start_ok   = (level_q >= LW'(START_LEVEL));

    // A pop only ever happens on the frame tick; an empty FIFO in RUN is an underrun, not a pop.
    assign pop        = tick && !fifo_empty && ((state_q == RUN) || start_ok);
    assign push       = s_valid && (!fifo_full || pop);
    assign vol_target = mute ? '1 : volume_req;
    assign mute_zero  = mute && (&out_volume_q);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_left_q[wr_ptr_q]  <= s_left;
            mem_right_q[wr_ptr_q] <= s_right;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            frame_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            out_volume_q <= '1;
            out_valid_q  <= 1'b0;
            running_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_cnt_q <= tick ? '0 : frame_cnt_q + CW'(1);
            out_valid_q <= tick;
            underrun_q  <= tick && (state_q == RUN) && fifo_empty;
            overrun_q   <= s_valid && fifo_full && !pop;
            level_q     <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (tick) begin
                if (pop && !mute_zero) begin
                    out_left_q  <= mem_left_q[rd_ptr_q];
                    out_right_q <= mem_right_q[rd_ptr_q];
                end else begin
                    out_left_q  <= '0;
                    out_right_q <= '0;
                end
                // One code step per frame keeps attenuation changes click-free.
                if (out_volume_q < vol_target) begin
                    out_volume_q <= out_volume_q + VOLUME_WIDTH'(1);
                end else if (out_volume_q > vol_target) begin
                    out_volume_q <= out_volume_q - VOLUME_WIDTH'(1);
                end
                case (state_q)
                    FILL: begin
                        if (start_ok) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (fifo_empty) begin
                            state_q   <= FILL;
                            running_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= FILL;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_left   = out_left_q;
    assign out_right  = out_right_q;
    assign out_volume = out_volume_q;
    assign out_valid  = out_valid_q;
    assign running    = running_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;
endmodule
